// File: rtl/boa_pkg.sv
// Shared definitions for the BOA instruction-fetch path.
//   BOA_ENTRY_PC : default reset fetch address
//   trap_cause_e : trap cause codes carried with fetch entries
//   pf_entry_t   : one prefetch-queue entry {pc[31:1], insn, trap, cause}
package boa_pkg;

    localparam logic [31:0] BOA_ENTRY_PC = 32'h4000_0000;

    typedef enum logic [3:0] {
        CAUSE_INSN_MISALIGNED   = 4'd0,
        CAUSE_INSN_ACCESS_FAULT = 4'd1,
        CAUSE_ILLEGAL_INSN      = 4'd2,
        CAUSE_BREAKPOINT        = 4'd3
    } trap_cause_e;

    typedef struct packed {
        logic [31:1] pc;
        logic [31:0] insn;
        logic        trap;
        logic [3:0]  cause;
    } pf_entry_t;

    localparam int PF_ENTRY_W = $bits(pf_entry_t);

endpackage

// File: rtl/boa_mem_bus.sv
// Instruction memory bus.
//   re    : request valid (master)
//   addr  : word address [31:2] (master)
//   ready : request accept (slave)
//   rdata : read data (slave)
// Handshake: a request is a cycle with re=1; it is accepted in that cycle
// when ready=1. The slave returns rdata exactly one cycle after acceptance,
// with no separate valid; the master tracks what it has in flight. While a
// request is not accepted, addr stays stable unless the master redirects.
interface boa_mem_bus;
    logic        re;
    logic [31:2] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output re, output addr, input ready, input rdata);
    modport slave  (input re, input addr, output ready, output rdata);
endinterface

// File: rtl/boa_prefetch_fifo.sv
// Prefetch queue: power-of-two ring buffer.
//   clk, rst       : clock, synchronous active-high reset
//   i_flush        : empty the queue at the next edge
//   i_push/i_wdata : enqueue an entry
//   i_pop          : dequeue the head entry
//   o_rdata        : head entry (valid when !o_empty)
//   o_full/o_empty : status
//   o_count        : occupancy, 0..DEPTH
// Push and pop in the same cycle on a full queue is allowed; occupancy is
// then unchanged.
module boa_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full   = (r_count == CNT_DEPTH);
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot being written, so a full queue may still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/boa_prefetch_if.sv
// Instruction prefetch unit: fetches sequentially from ENTRY_PC over pbus,
// buffers responses in a DEPTH-entry queue and presents one instruction per
// cycle to ID on the q_* registers.
//   clk, rst            : clock, synchronous active-high reset
//   pbus                : instruction fetch master (re/addr out, ready/rdata in)
//   q_valid/q_pc/q_insn : instruction to ID
//   q_trap/q_cause      : fetch trap marker and cause
//   id_branch_predict/id_branch_target  : ID predicted-taken redirect
//   fw_stall_if         : no new fetch requests
//   fw_stall_id         : hold the q_* outputs
//   fw_branch_correct/fw_branch_alt     : misprediction redirect
//   fw_exception/fw_tvec                : trap redirect
// Redirect priority: fw_exception > fw_branch_correct > id_branch_predict.
module boa_prefetch_if
    import boa_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ENTRY_PC = BOA_ENTRY_PC
) (
    input  logic        clk,
    input  logic        rst,
    boa_mem_bus.master  pbus,
    output logic        q_valid,
    output logic [31:1] q_pc,
    output logic [31:0] q_insn,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    input  logic        id_branch_predict,
    input  logic [31:1] id_branch_target,
    input  logic        fw_stall_if,
    input  logic        fw_stall_id,
    input  logic        fw_branch_correct,
    input  logic [31:1] fw_branch_alt,
    input  logic        fw_exception,
    input  logic [31:1] fw_tvec
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);

    // Fetch state
    logic [31:1] r_pc;          // next sequential fetch PC
    logic        r_halt;        // set after a misaligned redirect
    // Entry arriving this cycle: a bus response or a synthesised trap entry
    logic        r_in_pending;
    logic        r_in_trap;
    logic [31:1] r_in_pc;
    // ID-facing registers
    logic        r_q_valid;
    pf_entry_t   r_q_entry;

    logic        w_redirect;
    logic [31:1] w_target;
    logic        w_trap_issue;
    logic        w_re;
    logic [31:2] w_addr;
    logic        w_accept;
    logic        w_credit;
    logic [AW+1:0] w_inflight;
    logic        w_in_valid;
    pf_entry_t   w_in_entry;
    pf_entry_t   w_head;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_count;

    assign w_redirect   = fw_exception || fw_branch_correct || id_branch_predict;
    assign w_trap_issue = w_redirect && w_target[1];

    always_comb begin
        w_target = id_branch_target;
        if (fw_exception)           w_target = fw_tvec;
        else if (fw_branch_correct) w_target = fw_branch_alt;
    end

    // Credit counts queued entries plus the one that may be arriving, so a
    // request is only issued if its response is guaranteed a slot even when
    // ID stalls. The q_* register is not counted; it is extra storage.
    assign w_inflight = {1'b0, w_count} + {{(AW+1){1'b0}}, r_in_pending};
    assign w_credit   = (w_inflight < CREDIT_MAX);

    always_comb begin
        w_re   = 1'b0;
        w_addr = r_pc[31:2];
        if (rst) begin
            w_re = 1'b0;
        end else if (w_redirect) begin
            // Redirects bypass both stalls and the credit check (queue flushes).
            w_addr = w_target[31:2];
            w_re   = !w_target[1];
        end else begin
            w_re = !fw_stall_if && w_credit && !r_halt;
        end
    end

    assign pbus.re   = w_re;
    assign pbus.addr = w_addr;
    assign w_accept  = w_re && pbus.ready;

    // Anything arriving during a redirect belongs to the old stream.
    assign w_in_valid = r_in_pending && !w_redirect;

    always_comb begin
        w_in_entry    = '0;
        w_in_entry.pc = r_in_pc;
        if (r_in_trap) begin
            w_in_entry.trap  = 1'b1;
            w_in_entry.cause = CAUSE_INSN_MISALIGNED;
        end else begin
            w_in_entry.insn = pbus.rdata;
        end
    end

    // Arriving entries bypass straight to q_* only when the queue is empty
    // and ID is taking; otherwise they queue behind older entries.
    assign w_pop  = !w_redirect && !fw_stall_id && !w_empty;
    assign w_push = w_in_valid && (fw_stall_id || !w_empty) && (!w_full || w_pop);

    boa_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (PF_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in_entry),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= ENTRY_PC[31:1];
            r_halt       <= 1'b0;
            r_in_pending <= 1'b0;
            r_in_trap    <= 1'b0;
            r_in_pc      <= '0;
        end else begin
            r_in_pending <= w_accept || w_trap_issue;
            r_in_trap    <= w_trap_issue;
            if (w_redirect) begin
                r_in_pc <= w_target;
                r_halt  <= w_target[1];
                // PC is in halfword units: +2 is the next word.
                r_pc    <= w_accept ? (w_target + 31'd2) : w_target;
            end else begin
                r_in_pc <= r_pc;
                if (w_accept) r_pc <= r_pc + 31'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_valid <= 1'b0;
            r_q_entry <= '0;
        end else if (w_redirect) begin
            r_q_valid <= 1'b0;
        end else if (!fw_stall_id) begin
            if (!w_empty) begin
                r_q_valid <= 1'b1;
                r_q_entry <= w_head;
            end else if (w_in_valid) begin
                r_q_valid <= 1'b1;
                r_q_entry <= w_in_entry;
            end else begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign q_valid = r_q_valid;
    assign q_pc    = r_q_entry.pc;
    assign q_insn  = r_q_entry.insn;
    assign q_trap  = r_q_entry.trap;
    assign q_cause = r_q_entry.cause;

endmodule

// File: doc/boa_prefetch_if.md
BOA_PREFETCH_IF -- requirements
Module: boa_prefetch_if

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter ENTRY_PC, default 32'h4000_0000, SHALL be the PC fetched first after reset.
REQ-003 Ports SHALL be exactly the following (name, direction, width, meaning):
- clk  in  1  sole clock.
- rst  in  1  reset: synchronous, active-high.
- pbus  boa_mem_bus  -  instruction fetch master, using re, addr[31:2], ready and rdata[31:0].
- q_valid  out  1  instruction to ID is valid.
- q_pc  out  31  [31:1] PC of that instruction.
- q_insn  out  32  instruction word.
- q_trap  out  1  entry is a fetch trap.
- q_cause  out  4  trap cause.
- id_branch_predict  in  1  ID predicted-taken redirect.
- id_branch_target  in  31  [31:1] predicted target.
- fw_stall_if  in  1  issue no new fetches.
- fw_stall_id  in  1  hold the q_* outputs.
- fw_branch_correct  in  1  misprediction redirect.
- fw_branch_alt  in  31  [31:1] corrected PC.
- fw_exception  in  1  trap redirect.
- fw_tvec  in  31  [31:1] trap vector.

Function
REQ-004 A request SHALL be a cycle with pbus.re=1; it is accepted when pbus.ready=1, and its rdata SHALL be sampled exactly one cycle after acceptance.
REQ-005 While pbus.ready=0, pbus.addr SHALL be held stable unless a redirect occurs in the same cycle.
REQ-006 After each accepted request, the fetch PC SHALL advance by 4.
REQ-007 Redirect priority SHALL be fw_exception > fw_branch_correct > id_branch_predict; only the highest-priority asserted redirect SHALL take effect.
REQ-008 In a redirect cycle, the block SHALL:
- flush the queue and clear q_valid at the next edge;
- discard any in-flight response;
- drive pbus.addr from the redirect target in that same cycle, with re=1 unless the target is misaligned.
REQ-009 A redirect SHALL override fw_stall_if and fw_stall_id.
REQ-010 The block SHALL issue a request only when all of the following hold:
- fw_stall_if=0;
- queue occupancy plus outstanding requests is less than DEPTH;
- no misaligned-trap halt is active.
REQ-011 With fw_stall_id=0, the q_* registers SHALL load the queue head, or bypass the arriving response when the queue is empty; q_valid=0 when no entry is available.
REQ-012 With fw_stall_id=1, all q_* outputs SHALL hold, and responses SHALL enqueue; the credit rule in REQ-010 guarantees no overflow.
REQ-013 A simultaneous enqueue and dequeue on a full queue SHALL be legal and SHALL leave occupancy unchanged.
REQ-014 Queue pointers SHALL wrap modulo DEPTH, with log2(DEPTH)+1-bit occupancy.
REQ-015 A redirect target with bit[1]=1 SHALL produce a single entry with q_trap=1, q_cause=4'd0 (instruction address misaligned), q_pc=target and q_insn=0.
REQ-016 After a misaligned-trap entry, fetching SHALL halt until the next redirect.
REQ-017 Normal entries SHALL have q_trap=0 and q_cause=0.
REQ-018 Latency: a request accepted in cycle N SHALL give q_valid=1 in cycle N+2 when the queue is empty and fw_stall_id=0.

Reset
REQ-019 While rst=1, at the clock edge the block SHALL set:
- queue empty;
- outstanding count 0;
- q_valid=0, q_trap=0, q_cause=0, q_pc=0, q_insn=0;
- fetch PC = ENTRY_PC;
- trap halt cleared.
REQ-020 While rst=1, pbus.re SHALL be 0, and any response arriving in the first cycle after reset release SHALL be discarded.
REQ-021 In the first cycle after release, the block SHALL issue a request at ENTRY_PC.

Structure
REQ-022 Trap cause codes and the default ENTRY_PC SHALL reside in the shared package boa_pkg.
REQ-023 The queue SHALL be a sub-module boa_prefetch_fifo, parametrised by DEPTH and entry width (31+32+1+4 bits), with push/pop/full/empty/flush.

Verification
REQ-024 Reset release with ready=1 and DEPTH=4 -> addresses 4000_0000, 4000_0004, ... each cycle; q_valid from cycle 2; q_pc increments by 4.
REQ-025 fw_stall_id=1 for 8 cycles -> at most 4 outstanding plus queued entries, re drops to 0, no entry is lost; on release, entries are delivered in order with no gaps.
REQ-026 pbus.ready=0 for 3 cycles -> addr is held stable and no duplicate entries are produced.
REQ-027 id_branch_predict (target 0000_1000) and fw_branch_correct (alt 0000_2000) in the same cycle -> next addr is 0000_2000, and no entry from the older stream appears afterwards.
REQ-028 fw_exception with fw_tvec=0000_0102 -> one entry with q_trap=1, q_cause=0, q_pc=0000_0102; re stays 0 until the next redirect.
REQ-029 Redirect while the queue is full and a response is in flight -> q_valid=0 the next cycle, and the stale response is not enqueued.
